div_sequencer: RTL and testbench

//  Iterative radix-2 divider and its sequencing FSM for the E stage of the 5-stage MIPS pipe.

---
 rtl/div_sequencer_if.sv | 25 ++
 rtl/div_sequencer.sv | 136 +++++++++++++
 tb/tb_div_sequencer.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/div_sequencer_if.sv
// Handshake and result bundle between the E-stage datapath and the iterative divider.
// The pipeline side uses the master modport and the divider uses the slave modport.
interface div_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             div_startE;
  logic             div_signedE;
  logic [WIDTH-1:0] srcaE;
  logic [WIDTH-1:0] srcbE;
  logic             flush;
  logic             div_stallE;
  logic             div_validE;
  logic [WIDTH-1:0] div_hiE;
  logic [WIDTH-1:0] div_loE;

  modport master (
    output div_startE, div_signedE, srcaE, srcbE, flush,
    input  div_stallE, div_validE, div_hiE, div_loE
  );

  modport slave (
    input  div_startE, div_signedE, srcaE, srcbE, flush,
    output div_stallE, div_validE, div_hiE, div_loE
  );
endinterface

// File: rtl/div_sequencer.sv
// Radix-2 restoring divider for MIPS DIV/DIVU in the E stage.
// It produces one quotient bit per cycle, stalls the pipe while it works, and pulses valid with HI/LO.
module div_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic            clk,
  input  logic            resetn,
  div_sequencer_if.slave  bus
);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, ZERO, DONE} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic             negQuo_q, negQuo_d;
  logic             negRem_q, negRem_d;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  logic [WIDTH-1:0] absA, absB;
  logic [WIDTH:0]   shifted, diff;
  logic [WIDTH-1:0] stepRem, stepQuo;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      count_q  <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      div_q    <= '0;
      negQuo_q <= 1'b0;
      negRem_q <= 1'b0;
      valid_q  <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      div_q    <= div_d;
      negQuo_q <= negQuo_d;
      negRem_q <= negRem_d;
      valid_q  <= valid_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  // The dividend shifts through quo_q while the partial remainder grows in rem_q.
  always_comb begin
    absA = (bus.div_signedE && bus.srcaE[WIDTH-1]) ? -bus.srcaE : bus.srcaE;
    absB = (bus.div_signedE && bus.srcbE[WIDTH-1]) ? -bus.srcbE : bus.srcbE;

    shifted = {rem_q, quo_q[WIDTH-1]};
    diff    = shifted - {1'b0, div_q};
    if (!diff[WIDTH]) begin
      stepRem = diff[WIDTH-1:0];
      stepQuo = {quo_q[WIDTH-2:0], 1'b1};
    end else begin
      stepRem = shifted[WIDTH-1:0];
      stepQuo = {quo_q[WIDTH-2:0], 1'b0};
    end
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    div_d    = div_q;
    negQuo_d = negQuo_q;
    negRem_d = negRem_q;
    valid_d  = 1'b0;
    hi_d     = hi_q;
    lo_d     = lo_q;

    if (bus.flush) begin
      state_d = IDLE;
      count_d = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.div_startE) begin
            rem_d    = '0;
            quo_d    = absA;
            div_d    = absB;
            negQuo_d = bus.div_signedE & (bus.srcaE[WIDTH-1] ^ bus.srcbE[WIDTH-1]);
            negRem_d = bus.div_signedE & bus.srcaE[WIDTH-1];
            count_d  = '0;
            state_d  = (bus.srcbE == '0) ? ZERO : BUSY;
          end
        end
        BUSY: begin
          rem_d   = stepRem;
          quo_d   = stepQuo;
          count_d = count_q + 1'b1;
          if (count_q == CW'(WIDTH - 1)) begin
            state_d = DONE;
            count_d = '0;
            valid_d = 1'b1;
            lo_d    = negQuo_q ? -stepQuo : stepQuo;
            hi_d    = negRem_q ? -stepRem : stepRem;
          end
        end
        ZERO: begin
          // Divide by zero returns the unsigned magnitudes with no sign correction.
          rem_d   = quo_q;
          quo_d   = '1;
          state_d = DONE;
          valid_d = 1'b1;
          lo_d    = '1;
          hi_d    = quo_q;
        end
        DONE: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  assign bus.div_stallE = ~bus.flush &
                          (((state_q == IDLE) & bus.div_startE) |
                           (state_q == BUSY) | (state_q == ZERO));
  assign bus.div_validE = valid_q;
  assign bus.div_hiE    = hi_q;
  assign bus.div_loE    = lo_q;
endmodule

// File: tb/tb_div_sequencer.sv
// Directed and random checks of div_sequencer against an arithmetic reference model.
// Inputs change and outputs are sampled around the falling clock edge.
module tb_div_sequencer;
  localparam int WIDTH = 32;

  logic clk;
  logic resetn;
  int   vecs;
  int   miscompares;
  logic [WIDTH-1:0] heldLo, heldHi;
  logic [WIDTH-1:0] dutLo, dutHi;

  div_sequencer_if #(.WIDTH(WIDTH)) bus ();

  div_sequencer #(.WIDTH(WIDTH)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [WIDTH-1:0] observed,
                             input logic [WIDTH-1:0] expected);
    vecs++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic start, input logic sgn, input logic [WIDTH-1:0] a,
                               input logic [WIDTH-1:0] b, input logic fl);
    @(negedge clk);
    bus.div_startE  = start;
    bus.div_signedE = sgn;
    bus.srcaE       = a;
    bus.srcbE       = b;
    bus.flush       = fl;
    #1;
  endtask

  // Reference: MIPS semantics via 64-bit integer division (truncating toward zero).
  task automatic refDiv(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic sgn,
                        output logic [WIDTH-1:0] lo, output logic [WIDTH-1:0] hi);
    longint sa, sb, q, r;
    if (b == 0) begin
      lo = '1;
      hi = (sgn && a[WIDTH-1]) ? -a : a;
    end else begin
      sa = sgn ? longint'($signed(a)) : longint'({32'b0, a});
      sb = sgn ? longint'($signed(b)) : longint'({32'b0, b});
      q  = sa / sb;
      r  = sa % sb;
      lo = q[WIDTH-1:0];
      hi = r[WIDTH-1:0];
    end
  endtask

  task automatic runDivide(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic sgn);
    logic [WIDTH-1:0] eLo, eHi;
    int lat;
    refDiv(a, b, sgn, eLo, eHi);
    lat = (b == 0) ? 2 : WIDTH + 1;
    applyStimulus(1'b1, sgn, a, b, 1'b0);
    checkOutput("stall_start", WIDTH'(bus.div_stallE), 1);
    checkOutput("valid_at_start", WIDTH'(bus.div_validE), 0);
    for (int c = 1; c <= lat; c++) begin
      applyStimulus(1'b0, 1'($urandom), $urandom, $urandom, 1'b0);
      if (c < lat) begin
        checkOutput("stall_busy", WIDTH'(bus.div_stallE), 1);
        checkOutput("valid_busy", WIDTH'(bus.div_validE), 0);
        checkOutput("lo_hold", bus.div_loE, heldLo);
        checkOutput("hi_hold", bus.div_hiE, heldHi);
      end else begin
        checkOutput("stall_done", WIDTH'(bus.div_stallE), 0);
        checkOutput("valid_done", WIDTH'(bus.div_validE), 1);
        checkOutput("lo_result", bus.div_loE, eLo);
        checkOutput("hi_result", bus.div_hiE, eHi);
        dutLo  = bus.div_loE;
        dutHi  = bus.div_hiE;
        heldLo = eLo;
        heldHi = eHi;
      end
    end
  endtask

  initial begin
    logic [WIDTH-1:0] ra, rb;
    logic rs;
    vecs        = 0;
    miscompares = 0;
    heldLo      = '0;
    heldHi      = '0;
    resetn          = 1'b0;
    bus.div_startE  = 1'b0;
    bus.div_signedE = 1'b0;
    bus.srcaE       = '0;
    bus.srcbE       = '0;
    bus.flush       = 1'b0;

    applyStimulus(1'b0, 1'b0, 0, 0, 1'b0);
    checkOutput("reset_valid", WIDTH'(bus.div_validE), 0);
    checkOutput("reset_lo", bus.div_loE, 0);
    checkOutput("reset_hi", bus.div_hiE, 0);
    checkOutput("reset_stall", WIDTH'(bus.div_stallE), 0);
    @(negedge clk);
    resetn = 1'b1;

    // Directed: unsigned, signed, overflow wrap and divide by zero.
    runDivide(100, 7, 1'b0);
    checkOutput("t1_lo", dutLo, 14);
    checkOutput("t1_hi", dutHi, 2);
    runDivide(32'hFFFF_FFF9, 2, 1'b1);
    checkOutput("t2s_lo", dutLo, 32'hFFFF_FFFD);
    checkOutput("t2s_hi", dutHi, 32'hFFFF_FFFF);
    runDivide(32'hFFFF_FFF9, 2, 1'b0);
    checkOutput("t2u_lo", dutLo, 32'h7FFF_FFFC);
    checkOutput("t2u_hi", dutHi, 1);
    runDivide(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    checkOutput("t3_ovf_lo", dutLo, 32'h8000_0000);
    checkOutput("t3_ovf_hi", dutHi, 0);
    runDivide(5, 0, 1'b0);
    checkOutput("t3_dz_lo", dutLo, 32'hFFFF_FFFF);
    checkOutput("t3_dz_hi", dutHi, 5);

    // Flush at cycle 10 of a running divide, then restart at cycle 12.
    applyStimulus(1'b1, 1'b0, 100, 7, 1'b0);
    for (int c = 1; c < 10; c++) begin
      applyStimulus(1'b0, 1'b0, $urandom, $urandom, 1'b0);
      checkOutput("flush_pre_stall", WIDTH'(bus.div_stallE), 1);
    end
    applyStimulus(1'b0, 1'b0, 0, 0, 1'b1);
    checkOutput("flush_stall", WIDTH'(bus.div_stallE), 0);
    applyStimulus(1'b0, 1'b0, 0, 0, 1'b0);
    checkOutput("flush_idle_stall", WIDTH'(bus.div_stallE), 0);
    checkOutput("flush_idle_valid", WIDTH'(bus.div_validE), 0);
    checkOutput("flush_lo_kept", bus.div_loE, heldLo);
    checkOutput("flush_hi_kept", bus.div_hiE, heldHi);
    runDivide(100, 7, 1'b0);

    // Flush beats a simultaneous start.
    applyStimulus(1'b1, 1'b0, 100, 7, 1'b1);
    checkOutput("flush_start_stall", WIDTH'(bus.div_stallE), 0);
    for (int c = 0; c < 3; c++) begin
      applyStimulus(1'b0, 1'b0, 0, 0, 1'b0);
      checkOutput("flush_start_idle", WIDTH'(bus.div_stallE), 0);
      checkOutput("flush_start_valid", WIDTH'(bus.div_validE), 0);
    end

    // Back-to-back divides.
    runDivide(100, 7, 1'b0);
    runDivide(9, 3, 1'b0);
    checkOutput("b2b_lo", dutLo, 3);
    checkOutput("b2b_hi", dutHi, 0);

    // Reset in the middle of a divide.
    applyStimulus(1'b1, 1'b0, 100, 7, 1'b0);
    for (int c = 1; c < 15; c++) applyStimulus(1'b0, 1'b0, $urandom, $urandom, 1'b0);
    @(negedge clk);
    bus.div_startE = 1'b0;
    resetn = 1'b0;
    #1;
    checkOutput("midreset_valid", WIDTH'(bus.div_validE), 0);
    checkOutput("midreset_lo", bus.div_loE, 0);
    checkOutput("midreset_hi", bus.div_hiE, 0);
    checkOutput("midreset_stall", WIDTH'(bus.div_stallE), 0);
    @(negedge clk);
    resetn = 1'b1;
    heldLo = '0;
    heldHi = '0;
    runDivide(100, 7, 1'b0);

    // Random operands, mixed signedness, nonzero divisors of varied magnitude.
    for (int i = 0; i < 24; i++) begin
      ra = $urandom;
      rs = 1'($urandom);
      case ($urandom_range(0, 2))
        0:       rb = 32'($urandom_range(1, 15));
        1:       rb = 32'($urandom_range(1, 65535));
        default: rb = $urandom;
      endcase
      if (rb == 0) rb = 1;
      if (rs && $urandom_range(0, 1) == 1) rb = -rb;
      runDivide(ra, rb, rs);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
    $finish;
  end
endmodule
